// File: rtl/program_store_if.sv
// Bus between program_store and its cpu / front-panel neighbours.
// PROG_CHECKSUM_EN adds the Checksum signal.
interface program_store_if #(
   parameter int n = 8
);
   logic [n-1:0] MemAddr;
   logic [n-1:0] MemData;
   logic         LoadMode;
   logic         LoadStrobe;
   logic [n-1:0] LoadData;
   logic         CpuHold;
   logic [n-1:0] LoadAddr;
   logic         LoadWrap;
`ifdef PROG_CHECKSUM_EN
   logic [n-1:0] Checksum;

   modport master (
      output MemAddr, LoadMode, LoadStrobe, LoadData,
      input  MemData, CpuHold, LoadAddr, LoadWrap, Checksum
   );
   modport slave (
      input  MemAddr, LoadMode, LoadStrobe, LoadData,
      output MemData, CpuHold, LoadAddr, LoadWrap, Checksum
   );
`else
   modport master (
      output MemAddr, LoadMode, LoadStrobe, LoadData,
      input  MemData, CpuHold, LoadAddr, LoadWrap
   );
   modport slave (
      input  MemAddr, LoadMode, LoadStrobe, LoadData,
      output MemData, CpuHold, LoadAddr, LoadWrap
   );
`endif
endinterface

// File: rtl/program_store.sv
// Writable instruction memory with a front-panel loader that holds the cpu while loading.
// Optional PROG_CHECKSUM_EN adds a running byte checksum of the current load session.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | cpu executing, memory read-only, strobes ignored
// LOAD     | cpu held, each strobe edge writes LoadData at LoadAddr
// RELEASE  | one extra held cycle so the cpu sees a full reset clock
module program_store #(
   parameter int n           = 8,
   parameter int DEPTH       = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic            Clock,
   input  logic            Reset,
   program_store_if.slave  bus
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   logic [SYNC_STAGES-1:0] mode_sync;
   logic [SYNC_STAGES-1:0] strobe_sync;
   logic                   strobe_prev;
   logic                   mode_s;
   logic                   strobe_s;
   logic                   strobe_edge;
   logic                   wr_en;

   logic [1:0]   state;
   logic         hold_q;
   logic [n-1:0] load_addr;
   logic         load_wrap;

   logic [n-1:0] mem [DEPTH];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         mode_sync   <= '0;
         strobe_sync <= '0;
         strobe_prev <= 1'b0;
      end else begin
         mode_sync   <= {mode_sync[SYNC_STAGES-2:0], bus.LoadMode};
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.LoadStrobe};
         strobe_prev <= strobe_s;
      end
   end

   assign mode_s      = mode_sync[SYNC_STAGES-1];
   assign strobe_s    = strobe_sync[SYNC_STAGES-1];
   assign strobe_edge = strobe_s & ~strobe_prev;
   // Reset forces state to RUN asynchronously, so a write in the reset cycle is dropped.
   assign wr_en       = (state == ST_LOAD) && strobe_edge;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= ST_RUN;
         hold_q    <= 1'b0;
         load_addr <= '0;
         load_wrap <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mode_s) begin
                  state     <= ST_LOAD;
                  hold_q    <= 1'b1;
                  load_addr <= '0;
                  load_wrap <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  load_addr <= load_addr + n'(1);
                  if (&load_addr) load_wrap <= 1'b1;
               end
               if (!mode_s) state <= ST_RELEASE;
            end
            ST_RELEASE: begin
               state  <= ST_RUN;
               hold_q <= 1'b0;
            end
            default: begin
               state  <= ST_RUN;
               hold_q <= 1'b0;
            end
         endcase
      end
   end

   // Program contents survive reset on purpose.
   always_ff @(posedge Clock) begin
      if (wr_en) mem[load_addr] <= bus.LoadData;
   end

   assign bus.MemData  = hold_q ? '0 : mem[bus.MemAddr];
   assign bus.CpuHold  = hold_q;
   assign bus.LoadAddr = load_addr;
   assign bus.LoadWrap = load_wrap;

`ifdef PROG_CHECKSUM_EN
   logic [n-1:0] checksum_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         checksum_q <= '0;
      end else if (state == ST_RUN && mode_s) begin
         checksum_q <= '0;
      end else if (wr_en) begin
         checksum_q <= checksum_q + bus.LoadData;
      end
   end

   assign bus.Checksum = checksum_q;
`else
`endif

endmodule
